// File: rtl/ram_event_arbiter.sv
// -----------------------------------------------------------------------------
// ram_event_arbiter
//
// Two show-ahead event FIFOs share the single HPS to-RAM event channel.
// The arbiter works one packet at a time. Once a source is granted, all of its
// words pass through before another source can be chosen. A packet is one
// header word followed by N payload words. The header must have [31:28] equal
// to MARKER and [15:0] = N with N <= MAX_LEN.
//
// When the head word of the chosen source is not a valid header, the arbiter
// pops that single word and counts an error. This lets upstream framing
// recover one word at a time.
//
// Ports
//   clk, reset               system clock; synchronous active-high reset
//   src0_data/empty/ack      source-0 FIFO head word, empty flag, pop strobe
//   src1_data/empty/ack      source-1 FIFO head word, empty flag, pop strobe
//   out_data/empty, out_ack  show-ahead view presented to the HPS, HPS pop
//   ctrl_enable              0 = start no new packets
//   hps_ctrl                 [0] clear counters, [1] mask src0,
//                            [2] mask src1, [3] fixed priority for src0
//   fpga_status              [1:0] grant (01 src0, 10 src1), [2] busy,
//                            [15:8] err_cnt, [31:16] pkt_cnt (registered)
// -----------------------------------------------------------------------------
module ram_event_arbiter #(
    parameter int unsigned MAX_LEN = 1023,
    parameter logic [3:0]  MARKER  = 4'hE
) (
    input  logic        clk,
    input  logic        reset,

    input  logic [31:0] src0_data,
    input  logic        src0_empty,
    output logic        src0_ack,

    input  logic [31:0] src1_data,
    input  logic        src1_empty,
    output logic        src1_ack,

    output logic [31:0] out_data,
    output logic        out_empty,
    input  logic        out_ack,

    input  logic        ctrl_enable,
    input  logic [31:0] hps_ctrl,
    output logic [31:0] fpga_status
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOCK = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        sel_q, sel_d;          // source owning the current LOCK/DROP
    logic        rr_ptr_q, rr_ptr_d;    // round-robin start point
    logic [16:0] remaining_q, remaining_d;
    logic [7:0]  err_cnt_q, err_cnt_d;
    logic [15:0] pkt_cnt_q, pkt_cnt_d;
    logic [31:0] status_q, status_d;

    logic        err_inc;
    logic        pkt_inc;
    logic        accept;
    logic        pick;
    logic        any_eligible;
    logic [1:0]  grant;
    logic        busy;

    // Per-source views, indexed by source number.
    logic [31:0] src_data [2];
    logic [1:0]  src_empty;
    logic [1:0]  src_mask;
    logic [1:0]  sel_onehot;
    logic [1:0]  eligible;
    logic [1:0]  hdr_ok;
    logic [1:0]  src_ack;

    assign src_data[0] = src0_data;
    assign src_data[1] = src1_data;
    assign src_empty   = {src1_empty, src0_empty};
    assign src_mask    = {hps_ctrl[2], hps_ctrl[1]};
    assign sel_onehot  = {sel_q, ~sel_q};

    // Upper control bits are reserved.
    logic unused_hps_bits;
    assign unused_hps_bits = ^hps_ctrl[31:4];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            assign eligible[gi] = ~src_empty[gi] & ~src_mask[gi] & ctrl_enable;

            // Bits [27:16] of a header carry no meaning for framing.
            assign hdr_ok[gi] = (src_data[gi][31:28] == MARKER) &&
                                ({16'd0, src_data[gi][15:0]} <= MAX_LEN);

            // The owner pops on HPS pops while it locks the channel. It pops
            // exactly once, without an HPS pop, when its head word is dropped.
            always_comb begin
                src_ack[gi] = 1'b0;
                if (sel_onehot[gi]) begin
                    if (state_q == ST_LOCK) begin
                        src_ack[gi] = out_ack & ~src_empty[gi];
                    end else if (state_q == ST_DROP) begin
                        src_ack[gi] = 1'b1;
                    end
                end
            end
        end
    endgenerate

    assign src0_ack = src_ack[0];
    assign src1_ack = src_ack[1];

    // Output pass-through only while a packet holds the channel.
    assign out_data  = (state_q == ST_LOCK) ? src_data[sel_q] : 32'd0;
    assign out_empty = (state_q == ST_LOCK) ? src_empty[sel_q] : 1'b1;
    assign accept    = out_ack & ~out_empty;

    // Selection. Fixed priority and a round-robin pointer at src0 both mean
    // "src0 if eligible, otherwise src1". A pointer at src1 means the reverse.
    assign any_eligible = |eligible;
    assign pick = (hps_ctrl[3] || !rr_ptr_q) ? ~eligible[0] : eligible[1];

    // Next-state logic.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        rr_ptr_d    = rr_ptr_q;
        remaining_d = remaining_q;
        err_inc     = 1'b0;
        pkt_inc     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (any_eligible) begin
                    sel_d = pick;
                    if (hdr_ok[pick]) begin
                        state_d     = ST_LOCK;
                        remaining_d = {1'b0, src_data[pick][15:0]} + 17'd1;
                    end else begin
                        state_d = ST_DROP;
                    end
                end
            end

            ST_LOCK: begin
                if (accept) begin
                    remaining_d = remaining_q - 17'd1;
                    if (remaining_q == 17'd1) begin
                        state_d  = ST_IDLE;
                        pkt_inc  = 1'b1;
                        rr_ptr_d = ~sel_q;
                    end
                end
            end

            ST_DROP: begin
                err_inc = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Counters. A clear request has priority over any increment in the same
    // cycle.
    always_comb begin
        err_cnt_d = err_cnt_q;
        pkt_cnt_d = pkt_cnt_q;
        if (hps_ctrl[0]) begin
            err_cnt_d = 8'd0;
            pkt_cnt_d = 16'd0;
        end else begin
            if (err_inc && (err_cnt_q != 8'hFF)) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
            if (pkt_inc) begin
                pkt_cnt_d = pkt_cnt_q + 16'd1;
            end
        end
    end

    // Status snapshot. It lags the internal state by one cycle.
    assign busy  = (state_q == ST_LOCK);
    assign grant = busy ? (sel_q ? 2'b10 : 2'b01) : 2'b00;

    always_comb begin
        status_d = {pkt_cnt_q, err_cnt_q, 5'd0, busy, grant};
    end

    assign fpga_status = status_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            sel_q       <= 1'b0;
            rr_ptr_q    <= 1'b0;
            remaining_q <= 17'd0;
            err_cnt_q   <= 8'd0;
            pkt_cnt_q   <= 16'd0;
            status_q    <= 32'd0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            rr_ptr_q    <= rr_ptr_d;
            remaining_q <= remaining_d;
            err_cnt_q   <= err_cnt_d;
            pkt_cnt_q   <= pkt_cnt_d;
            status_q    <= status_d;
        end
    end

endmodule

// File: tb/tb_ram_event_arbiter.sv
module tb_ram_event_arbiter;

    localparam int unsigned MAX_LEN = 1023;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] src0_data, src1_data;
    logic        src0_empty, src1_empty;
    logic        src0_ack, src1_ack;
    logic [31:0] out_data;
    logic        out_empty;
    logic        out_ack;
    logic        ctrl_enable;
    logic [31:0] hps_ctrl;
    logic [31:0] fpga_status;

    ram_event_arbiter #(.MAX_LEN(MAX_LEN), .MARKER(4'hE)) dut (
        .clk(clk), .reset(reset),
        .src0_data(src0_data), .src0_empty(src0_empty), .src0_ack(src0_ack),
        .src1_data(src1_data), .src1_empty(src1_empty), .src1_ack(src1_ack),
        .out_data(out_data), .out_empty(out_empty), .out_ack(out_ack),
        .ctrl_enable(ctrl_enable), .hps_ctrl(hps_ctrl), .fpga_status(fpga_status)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic [31:0] got[$];
    logic [31:0] exp_q[$];
    int ack0, ack1, bad_ack;

    task automatic refresh();
        src0_empty = (q0.size() == 0);
        src0_data  = (q0.size() != 0) ? q0[0] : 32'd0;
        src1_empty = (q1.size() == 0);
        src1_data  = (q1.size() != 0) ? q1[0] : 32'd0;
    endtask

    // One clock: drive out_ack, then sample outputs mid-cycle. Retire the
    // popped FIFO words just after the edge.
    task automatic step(input logic ack);
        logic a0, a1;
        @(negedge clk);
        out_ack = ack;
        #1;
        a0 = src0_ack;
        a1 = src1_ack;
        if (ack && !out_empty) got.push_back(out_data);
        if (a0 && src0_empty) bad_ack++;
        if (a1 && src1_empty) bad_ack++;
        if (a0 && a1) bad_ack++;
        @(posedge clk);
        #1;
        if (a0 && q0.size() != 0) begin void'(q0.pop_front()); ack0++; end
        if (a1 && q1.size() != 0) begin void'(q1.pop_front()); ack1++; end
        refresh();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        q0.delete(); q1.delete(); got.delete();
        ack0 = 0; ack1 = 0; bad_ack = 0;
        hps_ctrl = 32'd0; ctrl_enable = 1'b0; out_ack = 1'b0;
        refresh();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic push_pkt(input int which, input int n, input logic [31:0] tag);
        logic [31:0] w;
        w = {4'hE, 12'($urandom), 16'(n)};
        if (which == 0) q0.push_back(w); else q1.push_back(w);
        for (int i = 0; i < n; i++) begin
            w = tag + 32'(i);
            if (which == 0) q0.push_back(w); else q1.push_back(w);
        end
    endtask

    // Reference: walks the preloaded FIFOs packet by packet. It applies the
    // pick order and header rules directly and builds the expected stream.
    task automatic model(input logic fixed, input logic m0, input logic m1,
                         output int e_err, output int e_pkt,
                         output int e_a0, output int e_a1);
        logic [31:0] c0[$];
        logic [31:0] c1[$];
        logic [31:0] w;
        int rr, first, s, n;
        bit e0, e1;
        c0 = q0; c1 = q1;
        rr = 0; e_err = 0; e_pkt = 0; e_a0 = 0; e_a1 = 0;
        exp_q.delete();
        while (1) begin
            e0 = (c0.size() != 0) && !m0;
            e1 = (c1.size() != 0) && !m1;
            if (!e0 && !e1) break;
            first = fixed ? 0 : rr;
            if (first == 0) s = e0 ? 0 : 1; else s = e1 ? 1 : 0;
            w = (s == 0) ? c0[0] : c1[0];
            if (w[31:28] == 4'hE && 32'(w[15:0]) <= MAX_LEN) begin
                n = int'(w[15:0]);
                for (int i = 0; i <= n; i++) begin
                    if (s == 0) begin exp_q.push_back(c0.pop_front()); e_a0++; end
                    else        begin exp_q.push_back(c1.pop_front()); e_a1++; end
                end
                e_pkt = (e_pkt + 1) % 65536;
                rr = 1 - s;
            end else begin
                if (s == 0) begin void'(c0.pop_front()); e_a0++; end
                else        begin void'(c1.pop_front()); e_a1++; end
                if (e_err < 255) e_err++;
            end
        end
    endtask

    task automatic run_scenario(input string name, input logic fixed,
                                input logic m0, input logic m1, input int ack_pct);
        int e_err, e_pkt, e_a0, e_a1, cyc, bad_idx;
        model(fixed, m0, m1, e_err, e_pkt, e_a0, e_a1);
        got.delete(); ack0 = 0; ack1 = 0; bad_ack = 0;
        hps_ctrl = {28'd0, fixed, m1, m0, 1'b0};
        ctrl_enable = 1'b1;
        cyc = 0;
        while (cyc < 20000 && !(got.size() >= exp_q.size() &&
               (q0.size() == 0 || m0) && (q1.size() == 0 || m1))) begin
            step(1'($urandom_range(99) < ack_pct));
            cyc++;
        end
        repeat (6) step(1'b1);
        total_cnt++;
        if (cyc >= 20000) $display("FAIL %s timeout: got %0d words, need %0d", name, got.size(), exp_q.size());
        else pass_cnt++;
        bad_idx = -1;
        for (int i = 0; i < exp_q.size(); i++)
            if (bad_idx < 0 && (i >= got.size() || got[i] !== exp_q[i])) bad_idx = i;
        if (bad_idx < 0 && got.size() != exp_q.size()) bad_idx = exp_q.size();
        total_cnt++;
        if (bad_idx >= 0)
            $display("FAIL %s stream: word %0d got %h (%0d words), expected %h (%0d words)", name, bad_idx,
                     (bad_idx < got.size()) ? got[bad_idx] : 32'hx, got.size(),
                     (bad_idx < exp_q.size()) ? exp_q[bad_idx] : 32'hx, exp_q.size());
        else pass_cnt++;
        total_cnt++;
        if (fpga_status[15:8] !== 8'(e_err) || fpga_status[31:16] !== 16'(e_pkt) || fpga_status[2:0] !== 3'b000)
            $display("FAIL %s status: got %h, expected err=%0d pkt=%0d idle", name, fpga_status, e_err, e_pkt);
        else pass_cnt++;
        total_cnt++;
        if (ack0 != e_a0 || ack1 != e_a1 || bad_ack != 0)
            $display("FAIL %s acks: got %0d/%0d (bad %0d), expected %0d/%0d", name, ack0, ack1, bad_ack, e_a0, e_a1);
        else pass_cnt++;
        $display("%s: %0d words, err=%0d pkt=%0d", name, got.size(), e_err, e_pkt);
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk); #1;
        total_cnt++;
        if (out_empty !== 1'b1 || out_data !== 32'd0 || src0_ack !== 1'b0 || src1_ack !== 1'b0 || fpga_status !== 32'd0)
            $display("FAIL reset: out_empty=%b out_data=%h acks=%b%b status=%h, expected 1/0/00/0",
                     out_empty, out_data, src0_ack, src1_ack, fpga_status);
        else pass_cnt++;
        // Reset in the middle of a packet abandons it.
        push_pkt(0, 3, 32'hA000_0000);
        ctrl_enable = 1'b1;
        repeat (3) step(1'b1);
        reset = 1'b1;
        step(1'b0);
        reset = 1'b0;
        ctrl_enable = 1'b0;
        @(negedge clk); #1;
        total_cnt++;
        if (out_empty !== 1'b1 || fpga_status !== 32'd0 || src0_ack !== 1'b0)
            $display("FAIL reset_mid: out_empty=%b status=%h ack=%b, expected 1/0/0", out_empty, fpga_status, src0_ack);
        else pass_cnt++;
        $display("reset: done");
    endtask

    task automatic test_single_packet();
        int cyc;
        do_reset();
        q0.push_back(32'hE000_0002); q0.push_back(32'h1111_1111); q0.push_back(32'h2222_2222);
        refresh();
        ctrl_enable = 1'b1;
        step(1'b0);
        @(negedge clk); #1;
        total_cnt++;
        if (out_empty !== 1'b0 || out_data !== 32'hE000_0002)
            $display("FAIL hdr_latency: out_empty=%b out_data=%h, expected 0/E0000002", out_empty, out_data);
        else pass_cnt++;
        step(1'b0);
        total_cnt++;
        if (fpga_status[2:0] !== 3'b101)
            $display("FAIL lock_status: got %b, expected 101", fpga_status[2:0]);
        else pass_cnt++;
        cyc = 0;
        while (got.size() < 3 && cyc < 50) begin step(1'b1); cyc++; end
        repeat (4) step(1'b0);
        total_cnt++;
        if (got.size() != 3 || got[0] !== 32'hE000_0002 || got[1] !== 32'h1111_1111 || got[2] !== 32'h2222_2222 || ack0 != 3)
            $display("FAIL single_stream: %0d words, %0d acks, expected 3 words E0000002 11111111 22222222 and 3 acks",
                     got.size(), ack0);
        else pass_cnt++;
        total_cnt++;
        if (fpga_status !== 32'h0001_0000)
            $display("FAIL single_status: got %h, expected 00010000", fpga_status);
        else pass_cnt++;
        $display("single_packet: %0d words", got.size());
    endtask

    task automatic test_arbitration();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            push_pkt(0, 1, 32'hA000_0000 + 32'(i));
            push_pkt(1, 1, 32'hB000_0000 + 32'(i));
        end
        refresh();
        run_scenario("round_robin", 1'b0, 1'b0, 1'b0, 100);
        do_reset();
        for (int i = 0; i < 3; i++) begin
            push_pkt(0, 1, 32'hC000_0000 + 32'(i));
            push_pkt(1, 1, 32'hD000_0000 + 32'(i));
        end
        refresh();
        run_scenario("fixed_prio", 1'b1, 1'b0, 1'b0, 70);
        do_reset();
        push_pkt(0, 2, 32'h5000_0000);
        push_pkt(1, 2, 32'h6000_0000);
        refresh();
        run_scenario("mask_src1", 1'b0, 1'b0, 1'b1, 100);
        total_cnt++;
        if (q1.size() != 3) $display("FAIL mask_src1 untouched: src1 holds %0d words, expected 3", q1.size());
        else pass_cnt++;
    endtask

    task automatic test_drop();
        do_reset();
        q0.push_back(32'h1234_5678); q0.push_back(32'hE000_0000);
        refresh();
        run_scenario("bad_marker", 1'b0, 1'b0, 1'b0, 100);
        do_reset();
        push_pkt(0, int'(MAX_LEN), 32'h7000_0000);
        q0.push_back({4'hE, 12'd0, 16'(MAX_LEN + 1)});
        q0.push_back(32'hE000_0000);
        refresh();
        run_scenario("max_len", 1'b0, 1'b0, 1'b0, 100);
    endtask

    task automatic test_enable_drop();
        int cyc;
        do_reset();
        push_pkt(0, 4, 32'h9000_0000);
        q0.push_back(32'hE000_0000);
        refresh();
        ctrl_enable = 1'b1;
        cyc = 0;
        while (got.size() < 2 && cyc < 50) begin step(1'b1); cyc++; end
        ctrl_enable = 1'b0;
        while (got.size() < 5 && cyc < 100) begin step(1'b1); cyc++; end
        repeat (10) step(1'b1);
        total_cnt++;
        if (got.size() != 5 || got[4] !== 32'h9000_0003 || q0.size() != 1)
            $display("FAIL enable_drop: %0d words, src0 left %0d, expected 5 words and 1 left", got.size(), q0.size());
        else pass_cnt++;
        total_cnt++;
        if (out_empty !== 1'b1 || fpga_status[2:0] !== 3'b000 || fpga_status[31:16] !== 16'd1)
            $display("FAIL enable_drop idle: out_empty=%b status=%h, expected 1 and idle pkt=1", out_empty, fpga_status);
        else pass_cnt++;
        $display("enable_drop: %0d words", got.size());
    endtask

    task automatic test_ack_empty();
        do_reset();
        q0.push_back(32'hE000_0000);
        refresh();
        repeat (8) step(1'b1);
        total_cnt++;
        if (ack0 != 0 || got.size() != 0 || q0.size() != 1)
            $display("FAIL ack_idle: acks=%0d words=%0d, expected 0/0", ack0, got.size());
        else pass_cnt++;
        do_reset();
        q0.push_back(32'hE000_0002); q0.push_back(32'h4444_0001);
        refresh();
        ctrl_enable = 1'b1;
        repeat (10) step(1'b1);
        total_cnt++;
        if (got.size() != 2 || ack0 != 2 || bad_ack != 0 || out_empty !== 1'b1 || fpga_status[2:0] !== 3'b101)
            $display("FAIL starve: words=%0d acks=%0d bad=%0d empty=%b status=%b, expected 2/2/0/1/101",
                     got.size(), ack0, bad_ack, out_empty, fpga_status[2:0]);
        else pass_cnt++;
        q0.push_back(32'h4444_0002);
        refresh();
        repeat (5) step(1'b1);
        total_cnt++;
        if (got.size() != 3 || got[2] !== 32'h4444_0002 || fpga_status !== 32'h0001_0000)
            $display("FAIL starve_resume: words=%0d status=%h, expected 3 and 00010000", got.size(), fpga_status);
        else pass_cnt++;
        $display("ack_empty: %0d words", got.size());
    endtask

    task automatic test_clear();
        int cyc;
        do_reset();
        q0.push_back(32'h1234_5678); q0.push_back(32'hE000_0000);
        refresh();
        hps_ctrl = 32'd1;
        ctrl_enable = 1'b1;
        cyc = 0;
        while (got.size() < 1 && cyc < 50) begin step(1'b1); cyc++; end
        repeat (2) step(1'b1);
        hps_ctrl = 32'd0;
        repeat (3) step(1'b1);
        total_cnt++;
        if (got.size() != 1 || got[0] !== 32'hE000_0000 || fpga_status !== 32'd0)
            $display("FAIL clear: words=%0d status=%h, expected 1 word and 00000000", got.size(), fpga_status);
        else pass_cnt++;
        $display("clear: status=%h", fpga_status);
    endtask

    task automatic test_random();
        int np;
        for (int it = 0; it < 4; it++) begin
            do_reset();
            for (int s = 0; s < 2; s++) begin
                np = int'($urandom_range(3, 6));
                for (int p = 0; p < np; p++) begin
                    if ($urandom_range(99) < 20) begin
                        if ($urandom_range(1) == 0) begin
                            if (s == 0) q0.push_back({4'($urandom_range(13)), 28'($urandom)});
                            else        q1.push_back({4'($urandom_range(13)), 28'($urandom)});
                        end else begin
                            if (s == 0) q0.push_back({4'hE, 12'd0, 16'(MAX_LEN + 1 + $urandom_range(500))});
                            else        q1.push_back({4'hE, 12'd0, 16'(MAX_LEN + 1 + $urandom_range(500))});
                        end
                    end
                    push_pkt(s, int'($urandom_range(3)), $urandom);
                end
            end
            refresh();
            run_scenario($sformatf("random_%0d", it), 1'($urandom_range(1)), 1'b0, 1'b0,
                         int'($urandom_range(40, 100)));
        end
    endtask

    initial begin
        test_reset();
        test_single_packet();
        test_arbitration();
        test_drop();
        test_enable_drop();
        test_ack_empty();
        test_clear();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
